song_select_buttons: RTL and testbench



---
 rtl/song_nav_pkg.sv | 20 ++
 rtl/debounce_filter.sv | 47 ++++
 rtl/song_select_buttons.sv | 126 ++++++++++++
 tb/tb_song_select_buttons.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/song_nav_pkg.sv
// Shared definitions for the song-navigation button conditioning logic.
package song_nav_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2,
    LOCKED = 2'd3
  } nav_state_t;

  // Default timing for a 100 MHz clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 2_000_000;  // 20 ms
  localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000; // 500 ms
  localparam int unsigned DEF_REPEAT_CYCLES   = 20_000_000; // 200 ms

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a hold-time debounce counter for one button.
module debounce_filter
  import song_nav_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  // Accept a new level only after it has differed from stable for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (s != stable) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/song_select_buttons.sv
// Turns the raw next/previous buttons into single-cycle song pulses with
// auto-repeat on long presses and rejection of two-button chords.
module song_select_buttons
  import song_nav_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next_raw,
  input  logic       btn_prev_raw,
  output logic       next_song,
  output logic       prev_song,
  output logic [1:0] btn_level,
  output logic       repeating
);

  localparam int unsigned TW = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);

  // Index 0 is the "next" button, index 1 the "previous" button.
  logic [1:0]    stb;
  logic [1:0]    lv;
  logic [1:0]    rise;
  logic [1:0]    oth_stb;
  logic [1:0]    oth_rise;
  logic [1:0]    pulse;
  logic          repeating_nxt;
  nav_state_t    state_q   [2];
  nav_state_t    state_nxt [2];
  logic [TW-1:0] tcnt_q    [2];
  logic [TW-1:0] tcnt_nxt  [2];

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_next_raw),
    .stable (stb[0])
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_prev_raw),
    .stable (stb[1])
  );

  assign btn_level = stb;

  // Per-button press/hold/repeat/lock decisions; both FSMs see each other's debounced level.
  always_comb begin
    rise     = stb & ~lv;
    oth_stb  = {stb[0], stb[1]};
    oth_rise = {rise[0], rise[1]};
    pulse    = 2'b00;
    for (int unsigned i = 0; i < 2; i++) begin
      state_nxt[i] = state_q[i];
      tcnt_nxt[i]  = tcnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            if (oth_stb[i]) begin
              state_nxt[i] = LOCKED;
            end else begin
              pulse[i]     = 1'b1;
              tcnt_nxt[i]  = '0;
              state_nxt[i] = HELD;
            end
          end
        end
        HELD: begin
          if (!stb[i]) begin
            state_nxt[i] = IDLE;
          end else if (oth_rise[i]) begin
            state_nxt[i] = LOCKED;
          end else if (tcnt_q[i] == TW'(HOLD_CYCLES - 1)) begin
            pulse[i]     = 1'b1;
            tcnt_nxt[i]  = '0;
            state_nxt[i] = REPEAT;
          end else begin
            tcnt_nxt[i] = tcnt_q[i] + 1'b1;
          end
        end
        REPEAT: begin
          if (!stb[i]) begin
            state_nxt[i] = IDLE;
          end else if (oth_rise[i]) begin
            state_nxt[i] = LOCKED;
          end else if (tcnt_q[i] == TW'(REPEAT_CYCLES - 1)) begin
            pulse[i]    = 1'b1;
            tcnt_nxt[i] = '0;
          end else begin
            tcnt_nxt[i] = tcnt_q[i] + 1'b1;
          end
        end
        LOCKED: begin
          if (stb == 2'b00) begin
            state_nxt[i] = IDLE;
          end
        end
      endcase
    end
    repeating_nxt = (state_nxt[0] == REPEAT) | (state_nxt[1] == REPEAT);
  end

  // State, timers, edge-detect history and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= '{IDLE, IDLE};
      tcnt_q    <= '{'0, '0};
      lv        <= 2'b00;
      next_song <= 1'b0;
      prev_song <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      tcnt_q    <= tcnt_nxt;
      lv        <= stb;
      next_song <= pulse[0];
      prev_song <= pulse[1];
      repeating <= repeating_nxt;
    end
  end

endmodule

// File: tb/tb_song_select_buttons.sv
// Scoreboard bench for song_select_buttons with a behavioural reference model.
module tb_song_select_buttons;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned REP  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_next_raw = 1'b0;
  logic       btn_prev_raw = 1'b0;
  logic       next_song;
  logic       prev_song;
  logic [1:0] btn_level;
  logic       repeating;

  song_select_buttons #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_next_raw (btn_next_raw),
    .btn_prev_raw (btn_prev_raw),
    .next_song    (next_song),
    .prev_song    (prev_song),
    .btn_level    (btn_level),
    .repeating    (repeating)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ns;
    logic       ps;
    logic [1:0] lvl;
    logic       rep;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_cyc = 0;

  // Reference model: raw pipeline, debounce by run history, press age arithmetic.
  bit m_sy1[2];
  bit m_s[2];
  bit m_stb[2];
  bit m_lv[2];
  bit m_hist[2][$];
  bit m_act[2];
  int m_age[2];
  bit m_locked;

  function automatic bit pulse_due(input int age);
    return (age == HOLD) || (age > HOLD && ((age - HOLD) % REP) == 0);
  endfunction

  task automatic model_edge(input bit raw_n, input bit raw_p, input bit rst_n);
    bit   raw[2];
    bit   rise[2];
    bit   pul[2];
    bit   s_old;
    bit   all_diff;
    exp_t e;
    raw[0] = raw_n;
    raw[1] = raw_p;
    pul[0] = 1'b0;
    pul[1] = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_sy1[i] = 0; m_s[i] = 0; m_stb[i] = 0; m_lv[i] = 0;
        m_hist[i].delete();
        m_act[i] = 0; m_age[i] = 0;
      end
      m_locked = 0;
    end else begin
      for (int i = 0; i < 2; i++) rise[i] = m_stb[i] && !m_lv[i];
      if (m_locked) begin
        if (!m_stb[0] && !m_stb[1]) m_locked = 0;
      end else if ((rise[0] && m_stb[1]) || (rise[1] && m_stb[0])) begin
        m_locked = 1;
        m_act[0] = 0;
        m_act[1] = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (m_act[i] && !m_stb[i]) begin
            m_act[i] = 0;
          end else if (rise[i]) begin
            m_act[i] = 1;
            m_age[i] = 0;
            pul[i]   = 1;
          end else if (m_act[i]) begin
            m_age[i]++;
            if (pulse_due(m_age[i])) pul[i] = 1;
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        m_lv[i] = m_stb[i];
        s_old = m_s[i];
        m_hist[i].push_back(s_old);
        if (m_hist[i].size() > DB) void'(m_hist[i].pop_front());
        all_diff = (m_hist[i].size() == DB);
        foreach (m_hist[i][k]) if (m_hist[i][k] == m_stb[i]) all_diff = 0;
        if (all_diff) m_stb[i] = s_old;
        m_s[i]   = m_sy1[i];
        m_sy1[i] = raw[i];
      end
    end
    e.ns  = pul[0];
    e.ps  = pul[1];
    e.lvl = {m_stb[1], m_stb[0]};
    e.rep = (m_act[0] && m_age[0] >= HOLD) || (m_act[1] && m_age[1] >= HOLD);
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, let the edge happen, record what the model expects after it.
  task automatic cyc(input bit n, input bit p, input bit rst_n);
    btn_next_raw = n;
    btn_prev_raw = p;
    reset        = rst_n;
    @(posedge clk);
    model_edge(n, p, rst_n);
    #1;
  endtask

  task automatic run(input bit n, input bit p, input int k);
    repeat (k) cyc(n, p, 1'b1);
  endtask

  function automatic void chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, mon_cyc, act, exp);
    end
  endfunction

  // Monitor: compare every registered output against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("next_song", {1'b0, next_song}, {1'b0, e.ns});
        chk("prev_song", {1'b0, prev_song}, {1'b0, e.ps});
        chk("btn_level", btn_level, e.lvl);
        chk("repeating", {1'b0, repeating}, {1'b0, e.rep});
        mon_cyc++;
      end
    end
  end

  initial begin
    int  hold_n = 0;
    int  hold_p = 0;
    bit  lv_n = 0;
    bit  lv_p = 0;
    bit  rst_r;
    // Reset, then a clean press of next
    cyc(0, 0, 0); cyc(0, 0, 0);
    run(0, 0, 8); run(1, 0, 15); run(0, 0, 12);
    // Short glitches on prev never reach the debounced level
    run(0, 1, 3); run(0, 0, 3); run(0, 1, 2); run(0, 0, 12);
    // Long press of next with auto-repeat
    run(1, 0, 67); run(0, 0, 15);
    // Chord from a simultaneous press, then next alone
    run(1, 1, 40); run(0, 0, 15); run(1, 0, 12); run(0, 0, 15);
    // Next in repeat, prev joins; release prev then next
    run(1, 0, 37); run(1, 1, 20); run(1, 0, 20); run(0, 0, 15);
    // Reset during a repeating prev hold with the button kept down
    run(0, 1, 32); cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    run(0, 1, 40); run(0, 0, 15);
    // Randomised bouncing, long holds and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if (hold_n == 0) begin
        lv_n   = $urandom_range(0, 1);
        hold_n = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 8);
      end
      if (hold_p == 0) begin
        lv_p   = $urandom_range(0, 1);
        hold_p = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 8);
      end
      hold_n--;
      hold_p--;
      rst_r = ($urandom_range(0, 399) != 0);
      cyc(lv_n, lv_p, rst_r);
    end
    run(0, 0, 10);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
